booth_mult16_ctrl: RTL and testbench



---
 rtl/booth_mult16_ctrl_pkg.sv | 22 ++
 rtl/booth_mult16_ctrl_step_sel.sv | 47 ++++
 rtl/booth_mult16_ctrl.sv | 177 +++++++++++++++++
 tb/tb_booth_mult16_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_mult16_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// booth_mult16_ctrl_pkg
//
// Shared definitions for the iterative 16x16 multiplier controller:
//   - BM_WIDTH : operand width (must equal the external add/sub unit width)
//   - BM_CNT_W : iteration counter width (holds 0..BM_WIDTH)
//   - BM_ITERS : number of shift/add iterations per multiplication
//   - state_t  : controller FSM encoding (IDLE / RUN / DONE)
// ----------------------------------------------------------------------------
package booth_mult16_ctrl_pkg;

    localparam int BM_WIDTH = 16;
    localparam int BM_CNT_W = 5;
    localparam int BM_ITERS = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : booth_mult16_ctrl_pkg

// File: rtl/booth_mult16_ctrl_step_sel.sv
// ----------------------------------------------------------------------------
// booth_mult16_ctrl_step_sel (booth step selector)
//
// Combinational decode of one multiplier iteration.
//
// Ports:
//   signed_mode  in   1 = radix-2 Booth (two's complement), 0 = unsigned
//   q0           in   current LSB of the multiplier shift register
//   q_m1         in   previously shifted-out multiplier bit (Booth history)
//   use_m        out  1 = feed the multiplicand to the adder this iteration
//   sub          out  1 = subtract the multiplicand instead of adding it
// ----------------------------------------------------------------------------
module booth_mult16_ctrl_step_sel
    import booth_mult16_ctrl_pkg::*;
(
    input  logic signed_mode,
    input  logic q0,
    input  logic q_m1,
    output logic use_m,
    output logic sub
);

    always_comb begin
        use_m = 1'b0;
        sub   = 1'b0;
        if (signed_mode) begin
            // Booth pairs: 01 ends a run of ones (add), 10 starts one (subtract)
            unique case ({q0, q_m1})
                2'b01: begin
                    use_m = 1'b1;
                    sub   = 1'b0;
                end
                2'b10: begin
                    use_m = 1'b1;
                    sub   = 1'b1;
                end
                default: begin
                    use_m = 1'b0;
                    sub   = 1'b0;
                end
            endcase
        end else begin
            use_m = q0;
        end
    end

endmodule : booth_mult16_ctrl_step_sel

// File: rtl/booth_mult16_ctrl.sv
// ----------------------------------------------------------------------------
// booth_mult16_ctrl
//
// Iterative 16x16 multiplier controller wrapped around an external 16-bit
// add/sub unit. One iteration per clock, 16 iterations per product, with
// unsigned shift-add and signed radix-2 Booth modes.
//
// Ports:
//   clk           in   system clock, all state on rising edge
//   reset         in   synchronous active-high reset, clears all state
//   start         in   request, sampled only in IDLE
//   signed_mode   in   1 = two's complement Booth, 0 = unsigned (latched)
//   multiplicand  in   M operand (latched at start)
//   multiplier    in   Q operand (latched at start)
//   busy          out  high during the 16 RUN cycles
//   done          out  one-cycle pulse in DONE
//   product       out  32-bit result, valid from DONE until next start
//   add_a         out  adder operand A (accumulator high half)
//   add_b         out  adder operand B (M or 0)
//   add_sub       out  adder subtract select / carry-in (1 = A - B)
//   add_sum       in   adder result (combinational, same cycle)
//   add_cout      in   adder carry-out
// ----------------------------------------------------------------------------
module booth_mult16_ctrl
    import booth_mult16_ctrl_pkg::*;
#(
    parameter int WIDTH = BM_WIDTH,
    parameter int CNT_W = BM_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    output logic                 add_sub,
    input  logic [WIDTH-1:0]     add_sum,
    input  logic                 add_cout
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BM_ITERS - 1);

    // Bit shifted into the accumulator MSB. Unsigned keeps the adder carry;
    // signed rebuilds the true 17-bit sign so M = 0x8000 cannot overflow;
    // a skipped signed step is a plain arithmetic shift.
    function automatic logic shift_in_bit(
        input logic is_signed,
        input logic op,
        input logic a_msb,
        input logic b_msb,
        input logic sub,
        input logic cout,
        input logic acc_msb
    );
        if (!is_signed) begin
            return cout;
        end else if (op) begin
            return a_msb ^ (b_msb ^ sub) ^ cout;
        end else begin
            return acc_msb;
        end
    endfunction

    state_t                state_q,   state_d;
    logic [WIDTH-1:0]      m_q,       m_d;
    logic                  mode_q,    mode_d;
    logic [WIDTH-1:0]      acc_hi_q,  acc_hi_d;
    logic [WIDTH-1:0]      q_q,       q_d;
    logic                  q_m1_q,    q_m1_d;
    logic [CNT_W-1:0]      count_q,   count_d;
    logic [2*WIDTH-1:0]    product_q, product_d;

    logic                  use_m;
    logic                  sub_sel;
    logic                  shift_in;

    booth_mult16_ctrl_step_sel u_booth_step_sel (
        .signed_mode (mode_q),
        .q0          (q_q[0]),
        .q_m1        (q_m1_q),
        .use_m       (use_m),
        .sub         (sub_sel)
    );

    // Adder operands are only driven while iterating; quiet zeros otherwise.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_sub = 1'b0;
        if (state_q == ST_RUN) begin
            add_a = acc_hi_q;
            if (use_m) begin
                add_b   = m_q;
                add_sub = sub_sel;
            end
        end
    end

    assign shift_in = shift_in_bit(mode_q, use_m, add_a[WIDTH-1],
                                   add_b[WIDTH-1], add_sub, add_cout,
                                   acc_hi_q[WIDTH-1]);

    assign busy    = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);
    assign product = product_q;

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        mode_d    = mode_q;
        acc_hi_d  = acc_hi_q;
        q_d       = q_q;
        q_m1_d    = q_m1_q;
        count_d   = count_q;
        product_d = product_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    m_d      = multiplicand;
                    q_d      = multiplier;
                    mode_d   = signed_mode;
                    acc_hi_d = '0;
                    q_m1_d   = 1'b0;
                    count_d  = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                // {s, sum, q} >> 1, keeping the low 2*WIDTH bits
                acc_hi_d = {shift_in, add_sum[WIDTH-1:1]};
                q_d      = {add_sum[0], q_q[WIDTH-1:1]};
                q_m1_d   = q_q[0];
                count_d  = count_q + CNT_W'(1);
                if (count_q == LAST_CNT) begin
                    product_d = {acc_hi_d, q_d};
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            m_q       <= '0;
            mode_q    <= 1'b0;
            acc_hi_q  <= '0;
            q_q       <= '0;
            q_m1_q    <= 1'b0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            mode_q    <= mode_d;
            acc_hi_q  <= acc_hi_d;
            q_q       <= q_d;
            q_m1_q    <= q_m1_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

endmodule : booth_mult16_ctrl

// File: tb/tb_booth_mult16_ctrl.sv
// ----------------------------------------------------------------------------
// tb_booth_mult16_ctrl
//
// Directed bench for booth_mult16_ctrl paired with a behavioural 16-bit
// add/sub unit. Expected products are hand-computed constants.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_booth_mult16_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic        signed_mode;
    logic [15:0] multiplicand;
    logic [15:0] multiplier;
    logic        busy;
    logic        done;
    logic [31:0] product;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic        add_sub;
    logic [15:0] add_sum;
    logic        add_cout;

    int n_vec;
    int n_err;

    booth_mult16_ctrl #(
        .WIDTH (16),
        .CNT_W (5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .signed_mode  (signed_mode),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product),
        .add_a        (add_a),
        .add_b        (add_b),
        .add_sub      (add_sub),
        .add_sum      (add_sum),
        .add_cout     (add_cout)
    );

    // Behavioural add/sub unit: A + (B ^ {16{sub}}) + sub
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b ^ {16{add_sub}}}
                                 + {16'd0, add_sub};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one multiplication and follow it until done (bounded).
    // Cycle 1 is the sample just after the edge that accepts start.
    task automatic run_mult(input logic mode, input logic [15:0] m,
                            input logic [15:0] q, input logic hold_start,
                            output logic [31:0] prod, output int busy_cnt,
                            output int done_cyc, output int sub_cnt);
        @(negedge clk);
        signed_mode  = mode;
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        busy_cnt     = 0;
        done_cyc     = -1;
        sub_cnt      = 0;
        prod         = 32'hxxxx_xxxx;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (!hold_start) begin
                start = 1'b0;
            end else begin
                multiplicand = ~m;
                multiplier   = q ^ 16'h5a5a;
                signed_mode  = ~mode;
            end
            if (busy) busy_cnt++;
            if (busy && add_sub) sub_cnt++;
            if (done) begin
                done_cyc = c;
                prod     = product;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        signed_mode = 1'b0;
        multiplicand = 16'h0;
        multiplier = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: busy=%b done=%b expected 0 0", busy, done);
        end
        n_vec++;
        if (product !== 32'h0) begin
            n_err++;
            $display("FAIL reset_product: got %h expected 00000000", product);
        end
        n_vec++;
        if (add_a !== 16'h0 || add_b !== 16'h0 || add_sub !== 1'b0) begin
            n_err++;
            $display("FAIL reset_adder: a=%h b=%h sub=%b expected 0 0 0", add_a, add_b, add_sub);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_no_start: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_unsigned();
        logic [15:0] ms [4] = '{16'h0003, 16'hFFFF, 16'h0000, 16'h1234};
        logic [15:0] qs [4] = '{16'h0005, 16'hFFFF, 16'hABCD, 16'h0000};
        logic [31:0] ex [4] = '{32'h0000_000F, 32'hFFFE_0001, 32'h0, 32'h0};
        logic [31:0] p;
        int bc, dc, sc;
        for (int i = 0; i < 4; i++) begin
            run_mult(1'b0, ms[i], qs[i], 1'b0, p, bc, dc, sc);
            n_vec++;
            if (p !== ex[i]) begin
                n_err++;
                $display("FAIL unsigned_product[%0d]: got %h expected %h", i, p, ex[i]);
            end
            n_vec++;
            if (bc !== 16 || dc !== 17) begin
                n_err++;
                $display("FAIL unsigned_timing[%0d]: busy_cycles=%0d done_cycle=%0d expected 16 17", i, bc, dc);
            end
            n_vec++;
            if (sc !== 0) begin
                n_err++;
                $display("FAIL unsigned_sub[%0d]: sub_cycles=%0d expected 0", i, sc);
            end
            @(posedge clk);
            #1;
            n_vec++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL unsigned_done_pulse[%0d]: done=%b busy=%b expected 0 0", i, done, busy);
            end
        end
    endtask

    task automatic test_signed();
        logic [15:0] ms [4] = '{16'hFFFF, 16'h8000, 16'h8000, 16'h0007};
        logic [15:0] qs [4] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'hFFFD};
        logic [31:0] ex [4] = '{32'h0000_0001, 32'hC000_8000, 32'h4000_0000, 32'hFFFF_FFEB};
        int          es [4] = '{1, 1, 1, 2};
        logic [31:0] p;
        int bc, dc, sc;
        for (int i = 0; i < 4; i++) begin
            run_mult(1'b1, ms[i], qs[i], 1'b0, p, bc, dc, sc);
            n_vec++;
            if (p !== ex[i]) begin
                n_err++;
                $display("FAIL signed_product[%0d]: got %h expected %h", i, p, ex[i]);
            end
            n_vec++;
            if (bc !== 16 || dc !== 17) begin
                n_err++;
                $display("FAIL signed_timing[%0d]: busy_cycles=%0d done_cycle=%0d expected 16 17", i, bc, dc);
            end
            n_vec++;
            if (sc !== es[i]) begin
                n_err++;
                $display("FAIL signed_sub[%0d]: sub_cycles=%0d expected %0d", i, sc, es[i]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] p;
        int bc, dc, sc;
        // start held high and operands scrambled throughout RUN
        run_mult(1'b0, 16'h00FF, 16'h0101, 1'b1, p, bc, dc, sc);
        n_vec++;
        if (p !== 32'h0000_FFFF) begin
            n_err++;
            $display("FAIL hold_start_product: got %h expected 0000ffff", p);
        end
        n_vec++;
        if (bc !== 16 || dc !== 17) begin
            n_err++;
            $display("FAIL hold_start_timing: busy_cycles=%0d done_cycle=%0d expected 16 17", bc, dc);
        end
        // start still high across the DONE edge must not restart
        @(posedge clk);
        #1;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL start_in_done: busy=%b done=%b expected 0 0", busy, done);
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        if (product !== 32'h0000_FFFF) begin
            n_err++;
            $display("FAIL product_hold: got %h expected 0000ffff", product);
        end
        run_mult(1'b1, 16'hFFF0, 16'h0003, 1'b0, p, bc, dc, sc);
        n_vec++;
        if (p !== 32'hFFFF_FFD0 || dc !== 17) begin
            n_err++;
            $display("FAIL restart_product: got %h at cycle %0d expected ffffffd0 at 17", p, dc);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] p;
        int bc, dc, sc;
        int done_seen;
        @(negedge clk);
        signed_mode  = 1'b0;
        multiplicand = 16'h1111;
        multiplier   = 16'h0F0F;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_flags: busy=%b done=%b expected 0 0", busy, done);
        end
        n_vec++;
        if (product !== 32'h0) begin
            n_err++;
            $display("FAIL midreset_product: got %h expected 00000000", product);
        end
        n_vec++;
        if (add_a !== 16'h0 || add_b !== 16'h0) begin
            n_err++;
            $display("FAIL midreset_adder: a=%h b=%h expected 0 0", add_a, add_b);
        end
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (done || busy) done_seen++;
        end
        n_vec++;
        if (done_seen !== 0) begin
            n_err++;
            $display("FAIL midreset_no_done: active_cycles=%0d expected 0", done_seen);
        end
        // reset and start together: reset wins
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_beats_start: busy=%b expected 0", busy);
        end
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        run_mult(1'b0, 16'h1234, 16'h0010, 1'b0, p, bc, dc, sc);
        n_vec++;
        if (p !== 32'h0001_2340 || dc !== 17) begin
            n_err++;
            $display("FAIL after_reset_product: got %h at cycle %0d expected 00012340 at 17", p, dc);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_back_to_back();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_booth_mult16_ctrl
